ram_access_sequencer: RTL and testbench

//  Sits directly downstream of the pipeline's cpu_ram_if.cpu port.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/ram_access_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ram_access_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory path.
//   ramstate_t  : handshake code returned to memory_control (FREE/BUSY/ACCESS/ERROR)
//   word_t      : 32-bit data/address word
//   seq_state_t : internal state of ram_access_sequencer. Its members carry a SEQ_
//                 prefix because ACCESS already names a ramstate_t member in this scope.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_WAIT   = 2'd1,
    SEQ_ACCESS = 2'd2,
    SEQ_ERR    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer
//   Turns level-held memREN/memWEN requests from memory_control into timed
//   accesses on a synchronous single-port SRAM. A request seen while idle is
//   reported BUSY for LAT+1 cycles, then ACCESS for exactly one cycle.
//
// Parameters
//   LAT        BUSY cycles spent in WAIT before ACCESS (1..15)
//   ADDR_BITS  SRAM word-index width (1..29)
//
// Ports
//   CLK, RST    clock / synchronous active-high reset
//   memaddr     byte address (bits [1:0] ignored)
//   memstore    write data
//   memREN      read request, held until ACCESS
//   memWEN      write request, held until ACCESS
//   ramload     read data, meaningful only while ramstate == ACCESS
//   ramstate    FREE / BUSY / ACCESS / ERROR
//   sram_addr   latched word index to SRAM
//   sram_wdata  latched write data to SRAM
//   sram_ren    SRAM read strobe (data returns on sram_rdata next cycle)
//   sram_wen    SRAM write strobe
//   sram_rdata  SRAM read data
//
// Build option
//   RAM_BOUND_CHECK_EN : when defined, a request with nonzero address bits
//   above the SRAM range is rejected with one ERROR cycle. When undefined
//   those bits are dropped and the access aliases into the SRAM.
module ram_access_sequencer
  import cpu_types_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int ADDR_BITS = 14
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  word_t                memaddr,
  input  word_t                memstore,
  input  logic                 memREN,
  input  logic                 memWEN,
  output word_t                ramload,
  output ramstate_t            ramstate,
  output logic [ADDR_BITS-1:0] sram_addr,
  output word_t                sram_wdata,
  output logic                 sram_ren,
  output logic                 sram_wen,
  input  word_t                sram_rdata
);

  if (LAT < 1 || LAT > 15) begin : g_lat_range
    $error("ram_access_sequencer: LAT must be in 1..15");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 29) begin : g_addr_range
    $error("ram_access_sequencer: ADDR_BITS must be in 1..29");
  end

  localparam logic [3:0] CNT_RELOAD = 4'(LAT - 1);

  seq_state_t state;
  logic [3:0] cnt;
  logic       lat_wr;   // latched request type: 1 = write

  logic [ADDR_BITS-1:0] req_idx;
  logic                 req_single;
  logic                 req_bad;
  logic                 req_changed;
  logic                 fire;

  assign req_idx    = memaddr[ADDR_BITS+1:2];
  assign req_single = memREN ^ memWEN;

`ifdef RAM_BOUND_CHECK_EN
  logic req_oob;
  assign req_oob = |memaddr[31:ADDR_BITS+2];
  assign req_bad = (memREN & memWEN) | (req_single & req_oob);
`else
  assign req_bad = memREN & memWEN;
`endif

  // Byte-offset bits never reach the SRAM; upper bits only matter with the
  // bound check enabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{memaddr[1:0], memaddr[31:ADDR_BITS+2]};

  // Any change in the held request while waiting restarts the wait.
  assign req_changed = (req_idx != sram_addr) || (memstore != sram_wdata) ||
                       (memWEN != lat_wr);

  // Last WAIT cycle of an unchanged request: the read strobe goes out now so
  // sram_rdata is ready in the ACCESS cycle.
  assign fire = (state == SEQ_WAIT) && !req_changed && (cnt == 4'd0);

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= SEQ_IDLE;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      lat_wr     <= 1'b0;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (req_bad) begin
            state <= SEQ_ERR;
          end else if (req_single) begin
            sram_addr  <= req_idx;
            sram_wdata <= memstore;
            lat_wr     <= memWEN;
            cnt        <= CNT_RELOAD;
            state      <= SEQ_WAIT;
          end
        end
        SEQ_WAIT: begin
          if (req_changed) begin
            sram_addr  <= req_idx;
            sram_wdata <= memstore;
            lat_wr     <= memWEN;
            cnt        <= CNT_RELOAD;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= SEQ_ACCESS;
          end
        end
        SEQ_ACCESS: state <= SEQ_IDLE;
        SEQ_ERR:    state <= SEQ_IDLE;
        default:    state <= SEQ_IDLE;
      endcase
    end
  end

  // Strobes are masked while RST is high so a reset never lets an access
  // through in the cycle it is applied.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    ramstate = FREE;
    ramload  = '0;
    sram_ren = 1'b0;
    sram_wen = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        if (memREN | memWEN) ramstate = BUSY;
      end
      SEQ_WAIT: begin
        ramstate = BUSY;
        sram_ren = fire && !lat_wr && !RST;
      end
      SEQ_ACCESS: begin
        ramstate = ACCESS;
        if (lat_wr) sram_wen = !RST;
        else        ramload  = sram_rdata;
      end
      SEQ_ERR: ramstate = ERROR;
      default: ramstate = FREE;
    endcase
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Self-checking bench for ram_access_sequencer (LAT=2, ADDR_BITS=14).
// Directed table for the documented scenarios, a hand-written reset-abort
// sequence, then randomized traffic against a deadline-based reference model.
module tb_ram_access_sequencer;
  import cpu_types_pkg::*;

  localparam int LAT = 2;
  localparam int AB  = 14;

  logic          CLK;
  logic          RST;
  word_t         memaddr, memstore;
  logic          memREN, memWEN;
  word_t         ramload;
  ramstate_t     ramstate;
  logic [AB-1:0] sram_addr;
  word_t         sram_wdata;
  logic          sram_ren, sram_wen;
  word_t         sram_rdata;

  ram_access_sequencer #(.LAT(LAT), .ADDR_BITS(AB)) dut (
    .CLK(CLK), .RST(RST),
    .memaddr(memaddr), .memstore(memstore),
    .memREN(memREN), .memWEN(memWEN),
    .ramload(ramload), .ramstate(ramstate),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_rdata(sram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SRAM macro: 1-cycle read latency.
  word_t sram_mem [0:(1<<AB)-1];
  always @(posedge CLK) begin
    if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
    if (sram_ren) sram_rdata <= sram_mem[sram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input word_t a, input word_t d);
    memREN   = ren;
    memWEN   = wen;
    memaddr  = a;
    memstore = d;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference memory contents as seen by the CPU.
  word_t model_mem [int];
  function automatic word_t mread(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  typedef struct {
    string     name;
    logic      ren, wen;
    word_t     addr, data;
    logic      chk_st;
    ramstate_t st;
    logic      chk_ld;
    word_t     ld;
    logic      ewen;
    word_t     waddr, wdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic ren, input logic wen,
                              input word_t a, input word_t d, input logic chk_st,
                              input ramstate_t st, input logic chk_ld, input word_t ld,
                              input logic ewen, input word_t waddr, input word_t wdata);
    vec_t v;
    v.name = name; v.ren = ren; v.wen = wen; v.addr = a; v.data = d;
    v.chk_st = chk_st; v.st = st; v.chk_ld = chk_ld; v.ld = ld;
    v.ewen = ewen; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  // Random-phase stimulus and model state.
  logic  cur_ren, cur_wen;
  word_t cur_addr, cur_data;
  bit    pend, err_now;
  int    due;
  int    m_idx;
  word_t m_data;
  bit    m_wr;

  function automatic word_t rand_addr();
    word_t a;
    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
`ifdef RAM_BOUND_CHECK_EN
    if ($urandom_range(0, 7) == 0) a[31:AB+2] = 16'($urandom_range(1, 65535));
`else
    if ($urandom_range(0, 3) == 0) a[31:AB+2] = 16'($urandom_range(1, 65535));
`endif
    return a;
  endfunction

  initial begin
    for (int i = 0; i < (1 << AB); i++) sram_mem[i] = 32'h0;
    sram_mem[16'h10] = 32'hDEADBEEF;  model_mem[16'h10] = 32'hDEADBEEF;
    sram_mem[16'h11] = 32'hCAFE0011;  model_mem[16'h11] = 32'hCAFE0011;
    sram_mem[0]      = 32'hA5A50000;  model_mem[0]      = 32'hA5A50000;

    RST = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", 32'(ramstate), 32'(FREE));
    check("rst_ren", 32'(sram_ren), 32'h0);
    check("rst_wen", 32'(sram_wen), 32'h0);
    check("rst_load", ramload, 32'h0);
    next_cycle();
    RST = 1'b0;

    // 1: read 0x40
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("t1_busy", 1, 0, 32'h40, 0, 1, BUSY, 0, 0, 0, 0, 0));
    vq.push_back(mk("t1_access", 1, 0, 32'h40, 0, 1, ACCESS, 1, 32'hDEADBEEF, 0, 0, 0));
    vq.push_back(mk("t1_free", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
    // 2: write 0x80 then read back
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("t2_wbusy", 0, 1, 32'h80, 32'h12345678, 1, BUSY, 0, 0, 0, 0, 0));
    vq.push_back(mk("t2_waccess", 0, 1, 32'h80, 32'h12345678, 1, ACCESS, 0, 0, 1, 32'h20, 32'h12345678));
    vq.push_back(mk("t2_wfree", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("t2_rbusy", 1, 0, 32'h80, 0, 1, BUSY, 0, 0, 0, 0, 0));
    vq.push_back(mk("t2_raccess", 1, 0, 32'h80, 0, 1, ACCESS, 1, 32'h12345678, 0, 0, 0));
    vq.push_back(mk("t2_rfree", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
    // 3: address changes in the 2nd BUSY cycle
    vq.push_back(mk("t3_busy0", 1, 0, 32'h40, 0, 1, BUSY, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("t3_busy", 1, 0, 32'h44, 0, 1, BUSY, 0, 0, 0, 0, 0));
    vq.push_back(mk("t3_access", 1, 0, 32'h44, 0, 1, ACCESS, 1, 32'hCAFE0011, 0, 0, 0));
    vq.push_back(mk("t3_free", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
    // 4: both requests
    vq.push_back(mk("t4_both", 1, 1, 32'h40, 0, 0, FREE, 0, 0, 0, 0, 0));
    vq.push_back(mk("t4_error", 0, 0, 32'h0, 0, 1, ERROR, 0, 0, 0, 0, 0));
    vq.push_back(mk("t4_free", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
    // 6: out-of-range address
`ifdef RAM_BOUND_CHECK_EN
    vq.push_back(mk("t6_req", 1, 0, 32'h0001_0000, 0, 0, FREE, 0, 0, 0, 0, 0));
    vq.push_back(mk("t6_error", 0, 0, 32'h0, 0, 1, ERROR, 0, 0, 0, 0, 0));
    vq.push_back(mk("t6_free", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
`else
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("t6_busy", 1, 0, 32'h0001_0000, 0, 1, BUSY, 0, 0, 0, 0, 0));
    vq.push_back(mk("t6_alias", 1, 0, 32'h0001_0000, 0, 1, ACCESS, 1, 32'hA5A50000, 0, 0, 0));
    vq.push_back(mk("t6_free", 0, 0, 32'h0, 0, 1, FREE, 0, 0, 0, 0, 0));
`endif

    foreach (vq[i]) begin
      drive(vq[i].ren, vq[i].wen, vq[i].addr, vq[i].data);
      @(negedge CLK);
      if (vq[i].chk_st) check({vq[i].name, "_state"}, 32'(ramstate), 32'(vq[i].st));
      if (vq[i].chk_ld) check({vq[i].name, "_load"}, ramload, vq[i].ld);
      if (vq[i].chk_st && vq[i].st != BUSY) check({vq[i].name, "_ren"}, 32'(sram_ren), 32'h0);
      check({vq[i].name, "_wen"}, 32'(sram_wen), 32'(vq[i].ewen));
      if (vq[i].ewen) begin
        check({vq[i].name, "_waddr"}, 32'(sram_addr), vq[i].waddr);
        check({vq[i].name, "_wdata"}, sram_wdata, vq[i].wdata);
      end
      next_cycle();
    end
    model_mem[16'h20] = 32'h12345678;

    // 5: reset during WAIT of a write must abort it
    drive(1'b0, 1'b1, 32'h100, 32'hBAD0BAD0);
    @(negedge CLK); check("t5_busy0", 32'(ramstate), 32'(BUSY));
    next_cycle();
    @(negedge CLK); check("t5_busy1", 32'(ramstate), 32'(BUSY));
    next_cycle();
    RST = 1'b1;
    @(negedge CLK); check("t5_rst_wen", 32'(sram_wen), 32'h0);
    next_cycle();
    RST = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK); check("t5_free", 32'(ramstate), 32'(FREE));
    for (int i = 0; i < 3; i++) begin
      check("t5_no_wen", 32'(sram_wen), 32'h0);
      next_cycle();
      @(negedge CLK);
    end
    check("t5_mem_untouched", sram_mem[16'h40], 32'h0);
    next_cycle();

    // Randomized traffic against the deadline model.
    pend = 0; err_now = 0; due = 0; m_idx = 0; m_data = 0; m_wr = 0;
    cur_ren = 0; cur_wen = 0; cur_addr = 0; cur_data = 0;
    for (int c = 0; c < 600; c++) begin
      int  r;
      int  idx_in;
      bit  oob;
      if (pend) begin
        r = $urandom_range(0, 15);
        if (r == 0)      cur_addr[AB+1:2] = AB'($urandom_range(0, 15));
        else if (r == 1) cur_data = $urandom;
        else if (r == 2) begin cur_ren = ~cur_ren; cur_wen = ~cur_wen; end
      end else begin
        r = $urandom_range(0, 19);
        cur_addr = rand_addr();
        cur_data = $urandom;
        if (r < 6)       begin cur_ren = 0; cur_wen = 0; end
        else if (r == 6) begin cur_ren = 1; cur_wen = 1; end
        else begin
          cur_wen = 1'($urandom_range(0, 1));
          cur_ren = ~cur_wen;
        end
      end
      drive(cur_ren, cur_wen, cur_addr, cur_data);
      @(negedge CLK);

      idx_in = int'(cur_addr[AB+1:2]);
`ifdef RAM_BOUND_CHECK_EN
      oob = |cur_addr[31:AB+2];
`else
      oob = 1'b0;
`endif
      check("rnd_excl", 32'(sram_ren & sram_wen), 32'h0);
      if (err_now) begin
        check("rnd_error", 32'(ramstate), 32'(ERROR));
        check("rnd_err_ren", 32'(sram_ren), 32'h0);
        check("rnd_err_wen", 32'(sram_wen), 32'h0);
        err_now = 0;
      end else if (pend) begin
        if (c == due) begin
          check("rnd_access", 32'(ramstate), 32'(ACCESS));
          check("rnd_acc_wen", 32'(sram_wen), 32'(m_wr));
          if (m_wr) begin
            check("rnd_waddr", 32'(sram_addr), 32'(m_idx));
            check("rnd_wdata", sram_wdata, m_data);
            model_mem[m_idx] = m_data;
          end else begin
            check("rnd_load", ramload, mread(m_idx));
          end
          pend = 0;
        end else begin
          check("rnd_busy", 32'(ramstate), 32'(BUSY));
          check("rnd_busy_wen", 32'(sram_wen), 32'h0);
          if (idx_in != m_idx || cur_data != m_data || cur_wen != m_wr) begin
            m_idx = idx_in; m_data = cur_data; m_wr = cur_wen;
            due = c + LAT + 1;
          end
        end
      end else begin
        check("rnd_idle_wen", 32'(sram_wen), 32'h0);
        if (!cur_ren && !cur_wen) begin
          check("rnd_free", 32'(ramstate), 32'(FREE));
        end else if ((cur_ren && cur_wen) || oob) begin
          err_now = 1;
        end else begin
          check("rnd_issue", 32'(ramstate), 32'(BUSY));
          m_idx = idx_in; m_data = cur_data; m_wr = cur_wen;
          pend = 1;
          due = c + LAT + 1;
        end
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
